// File: rtl/mpc_cycle_csr.sv
// mpc_cycle_csr: mixed-precision cycle CSR and weight operand-slice stage.
// Holds the cycle, format, ratio and skip-size CSRs. Forwards the current
// cycle, format and skip size to the ID-stage mixed-precision controller and
// absorbs that controller's next-cycle updates. On each ID->EX advance of a
// dotp it registers the weight sub-operand slice selected by the current cycle.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   csr_we_i/addr_i/wdata_i          CSR write port
//   csr_rdata_o                      CSR read data, combinational on csr_addr_i
//   wcsr_i, next_cycle_i             controller cycle update request
//   sel_i                            cycle source: 0/3 CSR, 1 CSR write, 2 controller
//   current_cycle_o                  forwarded cycle to controller
//   ivec_fmt_o, skip_size_o          format and skip-size fields
//   id_valid_i, ex_ready_i           ID/EX handshake
//   is_dotp_i, op_b_i                dotp flag and weight operand from ID
//   ex_valid_o, ex_cycle_o           EX slot valid and cycle used
//   ex_wslice_o                      selected weight slice, zero-extended
module mpc_cycle_csr #(
    parameter int unsigned NBITS_MIXED_CYCLES = 3,
    parameter int unsigned NBITS_MAX_KER      = 8,
    parameter int unsigned FMT_W              = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          csr_we_i,
    input  logic [11:0]                   csr_addr_i,
    input  logic [31:0]                   csr_wdata_i,
    output logic [31:0]                   csr_rdata_o,
    input  logic                          wcsr_i,
    input  logic [NBITS_MIXED_CYCLES-1:0] next_cycle_i,
    input  logic [1:0]                    sel_i,
    output logic [NBITS_MIXED_CYCLES-1:0] current_cycle_o,
    output logic [FMT_W-1:0]              ivec_fmt_o,
    output logic [NBITS_MAX_KER-1:0]      skip_size_o,
    input  logic                          id_valid_i,
    input  logic                          ex_ready_i,
    input  logic                          is_dotp_i,
    input  logic [31:0]                   op_b_i,
    output logic                          ex_valid_o,
    output logic [NBITS_MIXED_CYCLES-1:0] ex_cycle_o,
    output logic [31:0]                   ex_wslice_o
);

    localparam int unsigned NC = NBITS_MIXED_CYCLES;
    localparam int unsigned NK = NBITS_MAX_KER;
    localparam logic [11:0] ADDR_CONF  = 12'h00C;
    localparam logic [11:0] ADDR_CYCLE = 12'h00D;

    logic [NC-1:0]    cycle_q, cycle_d;
    logic [NC-1:0]    wr_shadow_q, wr_shadow_d;
    logic [NC-1:0]    nc_shadow_q, nc_shadow_d;
    logic [FMT_W-1:0] fmt_q, fmt_d;
    logic [1:0]       ratio_q, ratio_d;
    logic [NK-1:0]    skip_q, skip_d;
    logic             ex_valid_q, ex_valid_d;
    logic [NC-1:0]    ex_cycle_q, ex_cycle_d;
    logic [31:0]      ex_wslice_q, ex_wslice_d;

    logic             wr_conf, wr_cycle, conf_changes, fire;
    logic [NC-1:0]    cyc_mask;
    logic [2:0]       idx;
    logic [4:0]       shamt;
    logic [31:0]      shifted, slice;
    logic             unused_wdata;

    // Valid cycle bits for a ratio: x1 -> none, x2 -> 1, x4 -> 2, x8 -> 3.
    function automatic logic [NC-1:0] ratio_mask(input logic [1:0] r);
        case (r)
            2'd0:    return '0;
            2'd1:    return NC'(1);
            2'd2:    return NC'(3);
            default: return NC'(7);
        endcase
    endfunction

    assign wr_conf  = csr_we_i && (csr_addr_i == ADDR_CONF);
    assign wr_cycle = csr_we_i && (csr_addr_i == ADDR_CYCLE);
    assign cyc_mask = ratio_mask(ratio_q);
    assign conf_changes = (csr_wdata_i[FMT_W-1:0] != fmt_q) || (csr_wdata_i[9:8] != ratio_q);
    assign unused_wdata = ^csr_wdata_i;

    // CSR next state; cycle source priority: 0x00D write, format change, controller.
    always_comb begin
        cycle_d     = cycle_q;
        wr_shadow_d = wr_shadow_q;
        nc_shadow_d = nc_shadow_q;
        fmt_d       = fmt_q;
        ratio_d     = ratio_q;
        skip_d      = skip_q;
        if (wr_conf) begin
            fmt_d   = csr_wdata_i[FMT_W-1:0];
            ratio_d = csr_wdata_i[9:8];
            skip_d  = csr_wdata_i[16 +: NK];
        end
        if (wr_cycle) begin
            cycle_d     = csr_wdata_i[NC-1:0] & cyc_mask;
            wr_shadow_d = csr_wdata_i[NC-1:0] & cyc_mask;
        end else if (wr_conf && conf_changes) begin
            cycle_d = '0;
        end else if (wcsr_i) begin
            cycle_d = next_cycle_i & cyc_mask;
        end
        if (wcsr_i) begin
            nc_shadow_d = next_cycle_i & cyc_mask;
        end
    end

    // Forwarding mux lets the controller see its own update without a bubble.
    always_comb begin
        case (sel_i)
            2'd1:    current_cycle_o = wr_shadow_q;
            2'd2:    current_cycle_o = nc_shadow_q;
            default: current_cycle_o = cycle_q;
        endcase
    end

    // Chunk width is 32/ratio; the masked cycle picks which chunk.
    always_comb begin
        idx   = 3'(current_cycle_o & cyc_mask);
        shamt = '0;
        case (ratio_q)
            2'd1:    shamt = {idx[0], 4'd0};
            2'd2:    shamt = {idx[1:0], 3'd0};
            2'd3:    shamt = {idx, 2'd0};
            default: shamt = '0;
        endcase
        shifted = op_b_i >> shamt;
        case (ratio_q)
            2'd1:    slice = shifted & 32'h0000_FFFF;
            2'd2:    slice = shifted & 32'h0000_00FF;
            2'd3:    slice = shifted & 32'h0000_000F;
            default: slice = op_b_i;
        endcase
    end

    // EX slot: load on fire, drain when EX accepts without a fire, hold on stall.
    assign fire = id_valid_i && ex_ready_i && is_dotp_i;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_cycle_d  = ex_cycle_q;
        ex_wslice_d = ex_wslice_q;
        if (fire) begin
            ex_valid_d  = 1'b1;
            ex_cycle_d  = current_cycle_o;
            ex_wslice_d = slice;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q     <= '0;
            wr_shadow_q <= '0;
            nc_shadow_q <= '0;
            fmt_q       <= '0;
            ratio_q     <= '0;
            skip_q      <= '0;
            ex_valid_q  <= 1'b0;
            ex_cycle_q  <= '0;
            ex_wslice_q <= '0;
        end else begin
            cycle_q     <= cycle_d;
            wr_shadow_q <= wr_shadow_d;
            nc_shadow_q <= nc_shadow_d;
            fmt_q       <= fmt_d;
            ratio_q     <= ratio_d;
            skip_q      <= skip_d;
            ex_valid_q  <= ex_valid_d;
            ex_cycle_q  <= ex_cycle_d;
            ex_wslice_q <= ex_wslice_d;
        end
    end

    // CSR read-back; unmapped addresses and unused bits read 0.
    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            ADDR_CYCLE: csr_rdata_o[NC-1:0] = cycle_q;
            ADDR_CONF: begin
                csr_rdata_o[FMT_W-1:0] = fmt_q;
                csr_rdata_o[9:8]       = ratio_q;
                csr_rdata_o[16 +: NK]  = skip_q;
            end
            default: csr_rdata_o = '0;
        endcase
    end

    assign ivec_fmt_o  = fmt_q;
    assign skip_size_o = skip_q;
    assign ex_valid_o  = ex_valid_q;
    assign ex_cycle_o  = ex_cycle_q;
    assign ex_wslice_o = ex_wslice_q;

endmodule

// File: tb/tb_mpc_cycle_csr.sv
// tb_mpc_cycle_csr: directed stimulus with hand-computed expectations pushed
// into a scoreboard queue; a negedge monitor pops and compares them.
module tb_mpc_cycle_csr;

    localparam int unsigned NC = 3;
    localparam int unsigned NK = 8;
    localparam int unsigned FW = 4;

    localparam int W_RD  = 0;
    localparam int W_CUR = 1;
    localparam int W_FMT = 2;
    localparam int W_SKP = 3;
    localparam int W_EXV = 4;
    localparam int W_EXC = 5;
    localparam int W_EXW = 6;

    logic          clk;
    logic          rst_n;
    logic          csr_we_i;
    logic [11:0]   csr_addr_i;
    logic [31:0]   csr_wdata_i;
    logic [31:0]   csr_rdata_o;
    logic          wcsr_i;
    logic [NC-1:0] next_cycle_i;
    logic [1:0]    sel_i;
    logic [NC-1:0] current_cycle_o;
    logic [FW-1:0] ivec_fmt_o;
    logic [NK-1:0] skip_size_o;
    logic          id_valid_i;
    logic          ex_ready_i;
    logic          is_dotp_i;
    logic [31:0]   op_b_i;
    logic          ex_valid_o;
    logic [NC-1:0] ex_cycle_o;
    logic [31:0]   ex_wslice_o;

    mpc_cycle_csr #(
        .NBITS_MIXED_CYCLES(NC),
        .NBITS_MAX_KER     (NK),
        .FMT_W             (FW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_we_i       (csr_we_i),
        .csr_addr_i     (csr_addr_i),
        .csr_wdata_i    (csr_wdata_i),
        .csr_rdata_o    (csr_rdata_o),
        .wcsr_i         (wcsr_i),
        .next_cycle_i   (next_cycle_i),
        .sel_i          (sel_i),
        .current_cycle_o(current_cycle_o),
        .ivec_fmt_o     (ivec_fmt_o),
        .skip_size_o    (skip_size_o),
        .id_valid_i     (id_valid_i),
        .ex_ready_i     (ex_ready_i),
        .is_dotp_i      (is_dotp_i),
        .op_b_i         (op_b_i),
        .ex_valid_o     (ex_valid_o),
        .ex_cycle_o     (ex_cycle_o),
        .ex_wslice_o    (ex_wslice_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          which;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] actual(input int which);
        case (which)
            W_RD:    return csr_rdata_o;
            W_CUR:   return 32'(current_cycle_o);
            W_FMT:   return 32'(ivec_fmt_o);
            W_SKP:   return 32'(skip_size_o);
            W_EXV:   return 32'(ex_valid_o);
            W_EXC:   return 32'(ex_cycle_o);
            default: return ex_wslice_o;
        endcase
    endfunction

    task automatic expect_at(input string name, input int which, input logic [31:0] v);
        chk_t c;
        c.due   = cyc;
        c.which = which;
        c.exp   = v;
        c.name  = name;
        sb.push_back(c);
    endtask

    // Advance one cycle and return inputs to idle (EX ready, nothing issued).
    task automatic step();
        @(posedge clk);
        #1;
        csr_we_i   = 1'b0;
        wcsr_i     = 1'b0;
        sel_i      = 2'd0;
        id_valid_i = 1'b0;
        is_dotp_i  = 1'b0;
        ex_ready_i = 1'b1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we_i    = 1'b1;
        csr_addr_i  = a;
        csr_wdata_i = d;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        chk_t c;
        logic [31:0] a;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            c = sb.pop_front();
            a = actual(c.which);
            total++;
            if (c.due != cyc || a !== c.exp) begin
                bad++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", c.name, a, c.exp, cyc);
            end
        end
    end

    initial begin
        chk_t c;
        rst_n = 1'b1;
        csr_we_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0;
        wcsr_i = 1'b0; next_cycle_i = '0; sel_i = '0;
        id_valid_i = 1'b0; ex_ready_i = 1'b1; is_dotp_i = 1'b0; op_b_i = '0;
        #2 rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // Reset state
        step(); csr_addr_i = 12'h00C;
        expect_at("rst_rd_conf", W_RD, 32'h0);
        expect_at("rst_fmt", W_FMT, 32'h0);
        expect_at("rst_skip", W_SKP, 32'h0);
        expect_at("rst_cur", W_CUR, 32'h0);
        expect_at("rst_exv", W_EXV, 32'h0);
        expect_at("rst_exc", W_EXC, 32'h0);
        expect_at("rst_exw", W_EXW, 32'h0);
        step(); csr_addr_i = 12'h00D;
        expect_at("rst_rd_cycle", W_RD, 32'h0);

        // Configure fmt 1, ratio x4, skip 3
        step(); csr_write(12'h00C, 32'h0003_0201);
        expect_at("conf_before_edge", W_RD, 32'h0);
        step(); csr_addr_i = 12'h00C;
        expect_at("conf_readback", W_RD, 32'h0003_0201);
        expect_at("conf_fmt", W_FMT, 32'h1);
        expect_at("conf_skip", W_SKP, 32'h3);

        // Controller loop x4 with forwarding from the controller shadow
        step(); csr_addr_i = 12'h00D; wcsr_i = 1'b1; next_cycle_i = 3'd1; sel_i = 2'd2;
        expect_at("loop0_cur", W_CUR, 32'h0); expect_at("loop0_rd", W_RD, 32'h0);
        step(); wcsr_i = 1'b1; next_cycle_i = 3'd2; sel_i = 2'd2;
        expect_at("loop1_cur", W_CUR, 32'h1); expect_at("loop1_rd", W_RD, 32'h1);
        step(); wcsr_i = 1'b1; next_cycle_i = 3'd3; sel_i = 2'd2;
        expect_at("loop2_cur", W_CUR, 32'h2); expect_at("loop2_rd", W_RD, 32'h2);
        step(); wcsr_i = 1'b1; next_cycle_i = 3'd0; sel_i = 2'd2;
        expect_at("loop3_cur", W_CUR, 32'h3); expect_at("loop3_rd", W_RD, 32'h3);
        step();
        expect_at("loop4_cur", W_CUR, 32'h0); expect_at("loop4_rd", W_RD, 32'h0);

        // Simultaneous 0x00D write (2) and controller update (3)
        step(); csr_write(12'h00D, 32'h2); wcsr_i = 1'b1; next_cycle_i = 3'd3;
        step(); sel_i = 2'd2;
        expect_at("simul_ncshadow", W_CUR, 32'h3); expect_at("simul_cycle", W_RD, 32'h2);
        step(); sel_i = 2'd1;
        expect_at("simul_wrshadow", W_CUR, 32'h2);

        // Unmapped address: reads 0, write ignored
        step(); csr_write(12'h7C0, 32'hFFFF_FFFF);
        step(); csr_addr_i = 12'h7C0;
        expect_at("unmapped_rd", W_RD, 32'h0);
        step(); csr_addr_i = 12'h00D;
        expect_at("unmapped_keep_cycle", W_RD, 32'h2);
        step(); csr_addr_i = 12'h00C;
        expect_at("unmapped_keep_conf", W_RD, 32'h0003_0201);

        // x2: ratio change clears cycle, 0x00D write is masked
        step(); csr_write(12'h00C, 32'h0003_0101);
        step(); csr_write(12'h00D, 32'h7);
        expect_at("x2_ratio_clear", W_RD, 32'h0);
        step(); csr_addr_i = 12'h00D; sel_i = 2'd1;
        expect_at("x2_mask_cycle", W_RD, 32'h1); expect_at("x2_mask_shadow", W_CUR, 32'h1);
        step(); csr_write(12'h00C, 32'h0003_0301);
        step(); csr_addr_i = 12'h00D; wcsr_i = 1'b1; next_cycle_i = 3'd6;
        expect_at("x8_ratio_clear", W_RD, 32'h0);
        step(); sel_i = 2'd2;
        expect_at("x8_wcsr_cycle", W_RD, 32'h6); expect_at("x8_wcsr_cur", W_CUR, 32'h6);

        // x8 slice: cycle 5, then 3 stalled cycles with new operands
        step(); csr_write(12'h00D, 32'h5);
        step(); id_valid_i = 1'b1; is_dotp_i = 1'b1; op_b_i = 32'h8765_4321;
        expect_at("x8_fire_cur", W_CUR, 32'h5); expect_at("x8_pre_exv", W_EXV, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(); ex_ready_i = 1'b0; id_valid_i = 1'b1; is_dotp_i = 1'b1;
            op_b_i = 32'h1111_1111 * 32'(i + 1);
            expect_at("x8_stall_exv", W_EXV, 32'h1);
            expect_at("x8_stall_exc", W_EXC, 32'h5);
            expect_at("x8_stall_exw", W_EXW, 32'h6);
        end

        // Asynchronous reset during the stalled valid slot
        step(); ex_ready_i = 1'b0; id_valid_i = 1'b1; is_dotp_i = 1'b1; csr_addr_i = 12'h00C;
        total++;
        if (ex_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre_exv: got %b expected 1", ex_valid_o);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (ex_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL arst_now_exv: got %b expected 0", ex_valid_o);
        end
        total++;
        if (ex_cycle_o !== 3'd0) begin
            bad++;
            $display("FAIL arst_now_exc: got %0d expected 0", ex_cycle_o);
        end
        total++;
        if (ex_wslice_o !== 32'h0) begin
            bad++;
            $display("FAIL arst_now_exw: got 0x%08h expected 0", ex_wslice_o);
        end
        total++;
        if (csr_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL arst_now_rd_conf: got 0x%08h expected 0", csr_rdata_o);
        end
        total++;
        if (ivec_fmt_o !== 4'h0) begin
            bad++;
            $display("FAIL arst_now_fmt: got 0x%0h expected 0", ivec_fmt_o);
        end
        total++;
        if (skip_size_o !== 8'h0) begin
            bad++;
            $display("FAIL arst_now_skip: got 0x%0h expected 0", skip_size_o);
        end
        expect_at("arst_exv", W_EXV, 32'h0);
        expect_at("arst_exc", W_EXC, 32'h0);
        expect_at("arst_exw", W_EXW, 32'h0);
        expect_at("arst_rd_conf", W_RD, 32'h0);
        expect_at("arst_fmt", W_FMT, 32'h0);
        expect_at("arst_skip", W_SKP, 32'h0);
        expect_at("arst_cur", W_CUR, 32'h0);
        step(); csr_addr_i = 12'h00D;
        expect_at("arst_rd_cycle", W_RD, 32'h0);
        step(); rst_n = 1'b1;

        // x4 slice (cycle 2) then x1 pass-through
        step(); csr_write(12'h00C, 32'h0000_0200);
        step(); csr_write(12'h00D, 32'h2);
        step(); id_valid_i = 1'b1; is_dotp_i = 1'b1; op_b_i = 32'h8765_4321;
        expect_at("x4_fire_cur", W_CUR, 32'h2);
        step(); csr_write(12'h00C, 32'h0000_0000);
        expect_at("x4_exv", W_EXV, 32'h1);
        expect_at("x4_exc", W_EXC, 32'h2);
        expect_at("x4_exw", W_EXW, 32'h65);
        step(); id_valid_i = 1'b1; is_dotp_i = 1'b1; op_b_i = 32'hDEAD_BEEF;
        expect_at("drain_exv", W_EXV, 32'h0);
        expect_at("x1_fire_cur", W_CUR, 32'h0);
        step();
        expect_at("x1_exv", W_EXV, 32'h1);
        expect_at("x1_exc", W_EXC, 32'h0);
        expect_at("x1_exw", W_EXW, 32'hDEAD_BEEF);
        step(); step();

        while (sb.size() > 0) begin
            c = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got unchecked expected 0x%08h (due cycle %0d)", c.name, c.exp, c.due);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
